// File: rtl/specdrum_pkg.sv
// rtl/specdrum_pkg.sv - shared state encoding, port constants and defaults for the Specdrum sequencer
package specdrum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  localparam logic [7:0] PORT_DF = 8'hDF;
  localparam logic [7:0] PORT_FB = 8'hFB;
  localparam int DEPTH_DEFAULT   = 16;
  localparam int DIVIDER_DEFAULT = 80;

endpackage

// File: rtl/specdrum_fifo.sv
// rtl/specdrum_fifo.sv - ce-qualified synchronous sample FIFO with explicit occupancy counter
module specdrum_fifo
  import specdrum_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   level
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  // The caller only requests legal operations; the FIFO itself never refuses.
  always_comb begin
    do_push  = ce && push;
    do_pop   = ce && pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/specdrum_sequencer.sv
// rtl/specdrum_sequencer.sv - paced Specdrum DAC playback: OUT capture, FIFO, tick pacing, output register
// Optional: SPECDRUM_COVOX_EN also decodes Covox port FB into the same write path.
module specdrum_sequencer
  import specdrum_pkg::*;
#(
  parameter int         DEPTH   = DEPTH_DEFAULT,
  parameter int         DIVIDER = DIVIDER_DEFAULT,
  parameter logic [7:0] PORT    = PORT_DF,
  localparam int        AW      = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        iorq,
  input  logic        wr,
  input  logic [7:0]  d,
  input  logic [7:0]  a,
  output logic [7:0]  q,
  output logic [AW:0] level,
  output logic        overflow,
  output logic        underrun
);

  localparam int          CW       = $clog2(DIVIDER + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DIVIDER - 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] HALF_LVL = (AW + 1)'(DEPTH / 2);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    q_q, q_d;
  logic          prev_hit_q, prev_hit_d;
  logic          overflow_q, overflow_d;
  logic          underrun_q, underrun_d;
  logic          hit, push_req, push, pop, full, tick;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_level;

  specdrum_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .push  (push),
    .pop   (pop),
    .din   (d),
    .dout  (fifo_dout),
    .level (fifo_level)
  );

  always_comb begin
    hit = !iorq && !wr && (a == PORT);
`ifdef SPECDRUM_COVOX_EN
    hit = hit || (!iorq && !wr && (a == PORT_FB));
`endif
    push_req   = ce && hit && !prev_hit_q;
    full       = (fifo_level == FULL_LVL);
    tick       = ce && (state_q == ST_PLAY) && (cnt_q == '0);
    pop        = tick && (fifo_level != '0);
    // A full FIFO still accepts a write when a pop frees the slot on the same ce.
    push       = push_req && (!full || pop);
    prev_hit_d = ce ? hit : prev_hit_q;

    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    overflow_d = overflow_q;
    underrun_d = underrun_q;
    if (ce) begin
      overflow_d = push_req && full && !pop;
      underrun_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = RELOAD;
          if (push) state_d = ST_FILL;
        end
        ST_FILL: begin
          cnt_d = RELOAD;
          if (fifo_level >= HALF_LVL) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (cnt_q == '0) begin
            cnt_d = RELOAD;
            if (fifo_level != '0) begin
              q_d = fifo_dout;
            end else begin
              underrun_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // prev_hit resets high so a cycle already in progress at release is not captured.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= RELOAD;
      q_q        <= '0;
      prev_hit_q <= 1'b1;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      prev_hit_q <= prev_hit_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  assign q        = q_q;
  assign level    = fifo_level;
  assign overflow = overflow_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_specdrum_sequencer.sv
// tb/tb_specdrum_sequencer.sv - self-checking bench for specdrum_sequencer with an expected-sample queue
module tb_specdrum_sequencer;
  import specdrum_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce    = 1'b1;
  logic       iorq  = 1'b1;
  logic       wr    = 1'b1;
  logic [7:0] d     = 8'h00;
  logic [7:0] a     = 8'h00;
  logic [7:0] q;
  logic [4:0] level;
  logic       overflow;
  logic       underrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  specdrum_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .iorq     (iorq),
    .wr       (wr),
    .d        (d),
    .a        (a),
    .q        (q),
    .level    (level),
    .overflow (overflow),
    .underrun (underrun)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic out_cycle(input logic [7:0] port, input logic [7:0] val, input int len, input bit accept);
    a = port; d = val; iorq = 1'b0; wr = 1'b0;
    if (accept) exp_q.push_back(val);
    cyc(len);
    iorq = 1'b1; wr = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset;
    exp_q.delete();
    iorq = 1'b0; wr = 1'b0; a = PORT_DF; d = 8'h77;
    reset = 1'b0;
    cyc(3);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (overflow !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b und=%b want 0 0", overflow, underrun); end
    reset = 1'b1;
    cyc(4);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_held_hit: got level %0d want 0", level); end
    iorq = 1'b1; wr = 1'b1;
    cyc(1);
    checks++; if (level !== 5'd0 || dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_idle: got level %0d state %0d want 0 IDLE", level, dut.state_q); end
  endtask

  task automatic test_single;
    logic [4:0] exp_lvl;
    out_cycle(PORT_DF, 8'h55, 4, 1'b1);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL single_q: got %h want 00", q); end
    checks++; if (dut.state_q !== ST_FILL) begin errors++; $display("FAIL single_state: got %0d want FILL", dut.state_q); end
    out_cycle(8'h10, 8'h66, 2, 1'b0);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL other_port: got level %0d want 1", level); end
`ifdef SPECDRUM_COVOX_EN
    out_cycle(PORT_FB, 8'hAA, 2, 1'b1);
    exp_lvl = 5'd2;
`else
    out_cycle(PORT_FB, 8'hAA, 2, 1'b0);
    exp_lvl = 5'd1;
`endif
    checks++; if (level !== exp_lvl) begin errors++; $display("FAIL fb_port: got level %0d want %0d", level, exp_lvl); end
  endtask

  task automatic test_play;
    logic [7:0] exp;
    for (int i = 1; i <= 8; i++) out_cycle(PORT_DF, 8'(i), 1, 1'b1);
    checks++; if (dut.state_q !== ST_PLAY || level !== 5'd8) begin errors++; $display("FAIL play_enter: got state %0d level %0d want PLAY 8", dut.state_q, level); end
    cyc(79);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL play_before_tick: got %h want 00", q); end
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      exp = exp_q.pop_front();
      checks++; if (q !== exp) begin errors++; $display("FAIL play_sample%0d: got %h want %h", k, q, exp); end
      checks++; if (level !== 5'(exp_q.size())) begin errors++; $display("FAIL play_level%0d: got %0d want %0d", k, level, exp_q.size()); end
      if (k < 2) begin
        cyc(79);
        checks++; if (q !== exp) begin errors++; $display("FAIL play_hold%0d: got %h want %h", k, q, exp); end
      end
    end
  endtask

  task automatic test_ce_gate;
    ce = 1'b0;
    a = PORT_DF; d = 8'h99; iorq = 1'b0; wr = 1'b0;
    cyc(3);
    iorq = 1'b1; wr = 1'b1;
    cyc(2);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL ce_gate: got level %0d want 0", level); end
    ce = 1'b1;
    out_cycle(PORT_DF, 8'h99, 1, 1'b1);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL ce_resume: got level %0d want 1", level); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) out_cycle(PORT_DF, 8'(8'h10 + i), 1, 1'b1);
    checks++; if (level !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full: got level %0d ovf %b want 16 0", level, overflow); end
    a = PORT_DF; d = 8'h20; iorq = 1'b0; wr = 1'b0;
    cyc(1);
    checks++; if (overflow !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL ovf_pulse: got ovf %b level %0d want 1 16", overflow, level); end
    iorq = 1'b1; wr = 1'b1;
    cyc(1);
    checks++; if (overflow !== 1'b0 || level !== 5'd16) begin errors++; $display("FAIL ovf_clear: got ovf %b level %0d want 0 16", overflow, level); end
  endtask

  task automatic test_push_pop;
    logic [7:0] exp;
    int n;
    n = 0;
    while (n < 200 && q === 8'h00) begin
      cyc(1);
      n++;
    end
    checks++; if (q === 8'h00) begin errors++; $display("FAIL pp_wait: got no pop within 200 cycles, want a pop"); end
    exp = exp_q.pop_front();
    checks++; if (q !== exp || level !== 5'd15) begin errors++; $display("FAIL pp_first_pop: got q %h level %0d want %h 15", q, level, exp); end
    cyc(1);
    out_cycle(PORT_DF, 8'h30, 1, 1'b1);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL pp_refill: got level %0d want 16", level); end
    cyc(76);
`ifdef SPECDRUM_COVOX_EN
    a = PORT_FB;
`else
    a = PORT_DF;
`endif
    d = 8'hAA; iorq = 1'b0; wr = 1'b0;
    exp_q.push_back(8'hAA);
    cyc(1);
    exp = exp_q.pop_front();
    checks++; if (level !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL pp_same_ce: got level %0d ovf %b want 16 0", level, overflow); end
    checks++; if (q !== exp) begin errors++; $display("FAIL pp_q: got %h want %h", q, exp); end
    iorq = 1'b1; wr = 1'b1;
    cyc(1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_no_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_drain;
    logic [7:0] exp;
    logic [7:0] last;
    last = q;
    cyc(79);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++; if (q !== exp || level !== 5'(exp_q.size()) || underrun !== 1'b0) begin
        errors++; $display("FAIL drain: got q %h level %0d und %b want %h %0d 0", q, level, underrun, exp, exp_q.size());
      end
      last = exp;
      cyc(80);
    end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b want 1", underrun); end
    checks++; if (q !== last || level !== 5'd0) begin errors++; $display("FAIL underrun_hold: got q %h level %0d want %h 0", q, level, last); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL underrun_state: got %0d want IDLE", dut.state_q); end
    cyc(1);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b want 0", underrun); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset();
    test_play();
    test_reset();
    test_ce_gate();
    test_reset();
    test_overflow();
    test_push_pop();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
